// File: rtl/inst_fetch_ctrl_pkg.sv
// rtl/inst_fetch_ctrl_pkg.sv - shared fetch-stage constants and FSM state encoding
package inst_fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_CANCEL = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_hold_buf.sv
// rtl/inst_fetch_ctrl_hold_buf.sv - one-entry {pc, inst} buffer for words returned while decode is blocked
module if_hold_buf #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_i,
    input  logic          rd_i,
    input  logic          clr_i,
    input  logic [AW-1:0] pc_i,
    input  logic [DW-1:0] inst_i,
    output logic          valid_o,
    output logic [AW-1:0] pc_o,
    output logic [DW-1:0] inst_o
);

    logic          valid_q;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] inst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            if (clr_i) begin
                valid_q <= 1'b0;
            end else if (wr_i) begin
                valid_q <= 1'b1;
            end else if (rd_i) begin
                valid_q <= 1'b0;
            end
            if (wr_i && !clr_i) begin
                pc_q   <= pc_i;
                inst_q <= inst_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch controller and IF/ID pipeline register
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    output logic          fetch_stall,
    output logic          inst_req,
    output logic [AW-1:0] inst_addr,
    input  logic          inst_addr_ok,
    input  logic          inst_data_ok,
    input  logic [DW-1:0] inst_rdata,
    input  logic          flush,
    input  logic          id_allowin,
    output logic          id_valid,
    output logic [AW-1:0] id_pc,
    output logic [DW-1:0] id_inst,
    output logic          id_adel
);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] req_pc_q, req_pc_d;
    logic          id_valid_q, id_valid_d;
    logic [AW-1:0] id_pc_q, id_pc_d;
    logic [DW-1:0] id_inst_q, id_inst_d;
    logic          id_adel_q, id_adel_d;

    logic          slot_free;
    logic          misaligned;
    logic          req;
    logic          commit;
    logic [AW-1:0] commit_pc;
    logic [DW-1:0] commit_inst;
    logic          commit_adel;

    logic          hold_wr, hold_rd, hold_clr;
    logic          hold_valid;
    logic [AW-1:0] hold_pc;
    logic [DW-1:0] hold_inst;

    assign slot_free  = !id_valid_q || id_allowin;
    assign misaligned = (pc[1:0] != 2'b00);

    if_hold_buf #(
        .AW (AW),
        .DW (DW)
    ) u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (hold_wr),
        .rd_i    (hold_rd),
        .clr_i   (hold_clr),
        .pc_i    (req_pc_q),
        .inst_i  (inst_rdata),
        .valid_o (hold_valid),
        .pc_o    (hold_pc),
        .inst_o  (hold_inst)
    );

    always_comb begin
        state_d     = state_q;
        req_pc_d    = req_pc_q;
        req         = 1'b0;
        commit      = 1'b0;
        commit_pc   = '0;
        commit_inst = '0;
        commit_adel = 1'b0;
        hold_wr     = 1'b0;
        hold_rd     = 1'b0;
        hold_clr    = flush;

        unique case (state_q)
            S_REQ: begin
                req = !misaligned;
                if (flush) begin
                    if (req && inst_addr_ok) begin
                        state_d = S_CANCEL;
                    end
                end else if (misaligned) begin
                    if (slot_free) begin
                        commit      = 1'b1;
                        commit_pc   = pc;
                        commit_adel = 1'b1;
                    end
                end else if (inst_addr_ok) begin
                    req_pc_d = pc;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = inst_data_ok ? S_REQ : S_CANCEL;
                end else if (inst_data_ok) begin
                    if (slot_free) begin
                        commit      = 1'b1;
                        commit_pc   = req_pc_q;
                        commit_inst = inst_rdata;
                        state_d     = S_REQ;
                    end else begin
                        hold_wr = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_REQ;
                end else if (slot_free && hold_valid) begin
                    commit      = 1'b1;
                    commit_pc   = hold_pc;
                    commit_inst = hold_inst;
                    hold_rd     = 1'b1;
                    state_d     = S_REQ;
                end
            end
            S_CANCEL: begin
                // The returning word always belongs to the cancelled request, so
                // leave even on a repeated flush rather than wait for a second reply.
                if (inst_data_ok) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_adel_d  = id_adel_q;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (commit) begin
            id_valid_d = 1'b1;
            id_pc_d    = commit_pc;
            id_inst_d  = commit_inst;
            id_adel_d  = commit_adel;
        end else if (id_allowin) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            req_pc_q   <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_adel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_adel_q  <= id_adel_d;
        end
    end

    // The PC register moves only when the current PC's word is committed or a redirect lands.
    assign fetch_stall = rst || !(commit || flush);
    assign inst_req    = req && !rst;
    assign inst_addr   = pc;

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_adel  = id_adel_q;

endmodule
